// File: rtl/rbus_ring_stop.sv
// rbus_ring_stop: one rbus ring hop; forwards, ejects and merges local traffic with a bypass FIFO
module rbus_ring_stop #(
    parameter int          SIG_W      = 8,
    parameter int          ADDR_W     = 37,
    parameter logic [9:0]  DST_MASK   = 10'h3F0,
    parameter logic [9:0]  DST_VAL    = 10'h000,
    parameter int          FIFO_DEPTH = 2,
    parameter int          STARVE_LIM = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SIG_W-1:0]  ring_in_sig,
    input  logic [9:0]        ring_in_src,
    input  logic [9:0]        ring_in_dst,
    input  logic [ADDR_W-1:0] ring_in_addr,
    output logic              ring_in_can,
    output logic [SIG_W-1:0]  ring_out_sig,
    output logic [9:0]        ring_out_src,
    output logic [9:0]        ring_out_dst,
    output logic [ADDR_W-1:0] ring_out_addr,
    input  logic              ring_out_can,
    input  logic [SIG_W-1:0]  loc_sig,
    input  logic [9:0]        loc_src,
    input  logic [9:0]        loc_dst,
    input  logic [ADDR_W-1:0] loc_addr,
    input  logic              loc_want,
    output logic              loc_can,
    output logic [SIG_W-1:0]  ej_sig,
    output logic [9:0]        ej_src,
    output logic [9:0]        ej_dst,
    output logic [ADDR_W-1:0] ej_addr
);
    localparam int PKT_W = SIG_W + 20 + ADDR_W;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam int SW    = $clog2(STARVE_LIM + 1);

    logic [PKT_W-1:0] in_pkt, loc_pkt, out_q, out_d, ej_q, ej_d;
    logic [PKT_W-1:0] fifo_q [FIFO_DEPTH];
    logic [PW-1:0]    rd_q, wr_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [SW-1:0]    stv_q, stv_d;
    logic acc, hit, bcast, eject, fwd, load, starve, has, prio_loc;
    logic take_loc, take_fifo, take_in, push, pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_pkt  = {ring_in_sig, ring_in_src, ring_in_dst, ring_in_addr};
    assign loc_pkt = {loc_sig, loc_src, loc_dst, loc_addr};
    assign {ring_out_sig, ring_out_src, ring_out_dst, ring_out_addr} = out_q;
    assign {ej_sig, ej_src, ej_dst, ej_addr} = ej_q;

    // Slot arbitration: starving local, FIFO head, bypass input, idle local, then empty
    always_comb begin
        ring_in_can = !rst && (cnt_q != CW'(FIFO_DEPTH));
        acc         = |ring_in_sig && ring_in_can;
        bcast       = ring_in_dst == 10'h3FF;
        hit         = (ring_in_dst & DST_MASK) == DST_VAL;
        eject       = acc && (hit || bcast);
        fwd         = acc && (!hit || bcast);
        load        = !(|out_q[PKT_W-1 -: SIG_W]) || ring_out_can;
        starve      = stv_q == SW'(STARVE_LIM);
        has         = cnt_q != '0;
        prio_loc    = starve && loc_want;
        take_loc    = load && loc_want && (starve || (!has && !fwd));
        take_fifo   = load && !prio_loc && has;
        take_in     = load && !prio_loc && !has && fwd;
        loc_can     = !rst && take_loc;
        push        = fwd && !take_in;
        pop         = take_fifo;
        out_d       = !load ? out_q : take_loc ? loc_pkt : take_fifo ? fifo_q[rd_q] : take_in ? in_pkt : '0;
        ej_d        = eject ? in_pkt : '0;
        cnt_d       = cnt_q + CW'(push) - CW'(pop);
        stv_d       = (!loc_want || loc_can) ? '0 : starve ? stv_q : stv_q + 1'b1;
    end

    // Control state, output slot and eject register; reset discards everything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
            ej_q  <= '0;
            cnt_q <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            stv_q <= '0;
        end else begin
            out_q <= out_d;
            ej_q  <= ej_d;
            cnt_q <= cnt_d;
            rd_q  <= pop ? inc(rd_q) : rd_q;
            wr_q  <= push ? inc(wr_q) : wr_q;
            stv_q <= stv_d;
        end
    end

    // FIFO storage needs no reset since the count gates every read
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_q] <= in_pkt;
    end
endmodule

// File: tb/tb_rbus_ring_stop.sv
// tb_rbus_ring_stop: directed table, corner sequences and random traffic against a queue model
module tb_rbus_ring_stop;
    localparam int          DEPTH = 2;
    localparam int          LIM   = 8;
    localparam logic [9:0]  MASK  = 10'h3F0;
    localparam logic [9:0]  VAL   = 10'h000;

    typedef struct packed {
        logic [7:0]  sig;
        logic [9:0]  src;
        logic [9:0]  dst;
        logic [36:0] addr;
    } pkt_t;

    typedef struct {
        logic [7:0] sig;
        logic [9:0] dst;
        logic       oc, lw, ic, lc;
        logic [7:0] osig;
        logic [9:0] odst;
        logic [7:0] esig;
        logic [9:0] edst;
    } vec_t;

    logic clk = 0, rst = 0;
    logic [7:0] ring_in_sig, ring_out_sig, loc_sig, ej_sig;
    logic [9:0] ring_in_src, ring_in_dst, ring_out_src, ring_out_dst, loc_src, loc_dst, ej_src, ej_dst;
    logic [36:0] ring_in_addr, ring_out_addr, loc_addr, ej_addr;
    logic ring_in_can, ring_out_can, loc_want, loc_can;

    int total = 0, passed = 0;
    pkt_t m_out, m_ej;
    pkt_t m_q[$];
    int m_cnt;
    logic last_lc;

    rbus_ring_stop #(.SIG_W(8), .ADDR_W(37), .DST_MASK(MASK), .DST_VAL(VAL),
                     .FIFO_DEPTH(DEPTH), .STARVE_LIM(LIM)) dut (
        .clk(clk), .rst(rst),
        .ring_in_sig(ring_in_sig), .ring_in_src(ring_in_src), .ring_in_dst(ring_in_dst),
        .ring_in_addr(ring_in_addr), .ring_in_can(ring_in_can),
        .ring_out_sig(ring_out_sig), .ring_out_src(ring_out_src), .ring_out_dst(ring_out_dst),
        .ring_out_addr(ring_out_addr), .ring_out_can(ring_out_can),
        .loc_sig(loc_sig), .loc_src(loc_src), .loc_dst(loc_dst), .loc_addr(loc_addr),
        .loc_want(loc_want), .loc_can(loc_can),
        .ej_sig(ej_sig), .ej_src(ej_src), .ej_dst(ej_dst), .ej_addr(ej_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        total++;
        if (a !== e) $display("FAIL %s: got %0h expected %0h", n, a, e);
        else passed++;
    endtask

    task automatic drive(input pkt_t in, input logic oc, input logic lw, input pkt_t lp);
        {ring_in_sig, ring_in_src, ring_in_dst, ring_in_addr} = in;
        {loc_sig, loc_src, loc_dst, loc_addr} = lp;
        ring_out_can = oc;
        loc_want = lw;
    endtask

    task automatic do_reset();
        drive('0, 1'b0, 1'b0, '0);
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        m_out = '0; m_ej = '0; m_q.delete(); m_cnt = 0;
    endtask

    // One cycle of traffic checked against the queue-based reference model
    task automatic step(input pkt_t in, input logic oc, input logic lw, input pkt_t lp);
        logic exp_ic, a, ej, fw, load, grant;
        pkt_t nxt;
        drive(in, oc, lw, lp);
        exp_ic = m_q.size() < DEPTH;
        a      = (in.sig != 0) && exp_ic;
        ej     = a && (((in.dst & MASK) == VAL) || in.dst == 10'h3FF);
        fw     = a && (((in.dst & MASK) != VAL) || in.dst == 10'h3FF);
        load   = (m_out.sig == 0) || oc;
        grant  = 0;
        nxt    = m_out;
        if (load) begin
            if (m_cnt >= LIM && lw) begin grant = 1; nxt = lp; end
            else if (m_q.size() > 0) nxt = m_q.pop_front();
            else if (fw) begin nxt = in; fw = 0; end
            else if (lw) begin grant = 1; nxt = lp; end
            else nxt = '0;
        end
        if (fw) m_q.push_back(in);
        #1;
        chk("ring_in_can", ring_in_can, exp_ic);
        chk("loc_can", loc_can, grant);
        last_lc = loc_can;
        m_cnt = (!lw || grant) ? 0 : (m_cnt < LIM ? m_cnt + 1 : m_cnt);
        m_ej  = ej ? in : '0;
        m_out = nxt;
        @(posedge clk);
        #1;
        chk("ring_out", {ring_out_sig, ring_out_src, ring_out_dst, ring_out_addr}, m_out);
        chk("ej", {ej_sig, ej_src, ej_dst, ej_addr}, m_ej);
    endtask

    function automatic pkt_t mk(input logic [7:0] s, input logic [9:0] d, input int i);
        return '{sig: s, src: 10'(i), dst: d, addr: 37'(i * 7 + 3)};
    endfunction

    initial begin
        vec_t tbl[17];
        pkt_t lp, rin;
        logic lw_h;
        tbl[0]  = '{8'h01, 10'h050, 1'b1, 1'b0, 1'b1, 1'b0, 8'h01, 10'h050, 8'h00, 10'h000};
        tbl[1]  = '{8'h02, 10'h005, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 10'h000, 8'h02, 10'h005};
        tbl[2]  = '{8'h03, 10'h3FF, 1'b1, 1'b0, 1'b1, 1'b0, 8'h03, 10'h3FF, 8'h03, 10'h3FF};
        tbl[3]  = '{8'h00, 10'h000, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 10'h000, 8'h00, 10'h000};
        tbl[4]  = '{8'h11, 10'h050, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 10'h050, 8'h00, 10'h000};
        tbl[5]  = '{8'h12, 10'h051, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 10'h050, 8'h00, 10'h000};
        tbl[6]  = '{8'h13, 10'h052, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 10'h050, 8'h00, 10'h000};
        tbl[7]  = '{8'h14, 10'h053, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 10'h050, 8'h00, 10'h000};
        tbl[8]  = '{8'h14, 10'h053, 1'b1, 1'b0, 1'b0, 1'b0, 8'h12, 10'h051, 8'h00, 10'h000};
        tbl[9]  = '{8'h14, 10'h053, 1'b1, 1'b0, 1'b1, 1'b0, 8'h13, 10'h052, 8'h00, 10'h000};
        tbl[10] = '{8'h00, 10'h000, 1'b1, 1'b0, 1'b1, 1'b0, 8'h14, 10'h053, 8'h00, 10'h000};
        tbl[11] = '{8'h00, 10'h000, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 10'h000, 8'h00, 10'h000};
        tbl[12] = '{8'h00, 10'h000, 1'b1, 1'b1, 1'b1, 1'b1, 8'hAA, 10'h123, 8'h00, 10'h000};
        tbl[13] = '{8'h00, 10'h000, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 10'h000, 8'h00, 10'h000};
        tbl[14] = '{8'h21, 10'h050, 1'b1, 1'b1, 1'b1, 1'b0, 8'h21, 10'h050, 8'h00, 10'h000};
        tbl[15] = '{8'h00, 10'h000, 1'b1, 1'b1, 1'b1, 1'b1, 8'hAA, 10'h123, 8'h00, 10'h000};
        tbl[16] = '{8'h00, 10'h000, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 10'h000, 8'h00, 10'h000};
        lp = mk(8'hAA, 10'h123, 99);

        do_reset();
        chk("rst_out", {ring_out_sig, ej_sig}, 16'h0);
        for (int i = 0; i < 17; i++) begin
            drive(mk(tbl[i].sig, tbl[i].dst, i), tbl[i].oc, tbl[i].lw, lp);
            #1;
            chk($sformatf("tbl%0d_in_can", i), ring_in_can, tbl[i].ic);
            chk($sformatf("tbl%0d_loc_can", i), loc_can, tbl[i].lc);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_out", i), {ring_out_sig, ring_out_dst}, {tbl[i].osig, tbl[i].odst});
            chk($sformatf("tbl%0d_ej", i), {ej_sig, ej_dst}, {tbl[i].esig, tbl[i].edst});
        end

        do_reset();
        for (int k = 0; k < 10; k++) begin
            step(mk(8'(8'h40 + k), 10'h050, k), 1'b1, k <= LIM, lp);
            if (k == LIM) chk("starve_grant", last_lc, 1'b1);
        end
        chk("starve_displaced", ring_out_sig, 8'h48);

        do_reset();
        for (int k = 0; k < 3; k++) step(mk(8'(8'h60 + k), 10'h050, k), 1'b0, 1'b0, lp);
        loc_want = 1;
        rst = 1;
        #1;
        chk("mid_rst_out", {ring_out_sig, ring_out_src, ring_out_dst, ring_out_addr}, 65'h0);
        chk("mid_rst_ej", {ej_sig, ej_src, ej_dst, ej_addr}, 65'h0);
        chk("mid_rst_cans", {ring_in_can, loc_can}, 2'b00);
        @(posedge clk);
        #1 rst = 0;
        m_out = '0; m_ej = '0; m_q.delete(); m_cnt = 0;
        step(mk(8'h70, 10'h050, 7), 1'b1, 1'b0, lp);
        chk("post_rst_pass", ring_out_sig, 8'h70);

        do_reset();
        lw_h = 0;
        last_lc = 0;
        for (int c = 0; c < 600; c++) begin
            logic [9:0] d;
            case ($urandom_range(0, 3))
                0: d = 10'h050;
                1: d = 10'h005;
                2: d = 10'h3FF;
                default: d = 10'($urandom);
            endcase
            rin = mk(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255)), d, c);
            rin.addr = {5'h0, 32'($urandom)};
            if (!lw_h || last_lc) begin
                lw_h = $urandom_range(0, 2) == 0;
                lp = mk(8'($urandom_range(1, 255)), 10'($urandom), c + 1000);
            end
            step(rin, $urandom_range(0, 3) != 0, lw_h, lp);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
